// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// FSM state encoding and datapath width.
package hilo_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider core: one quotient bit per enabled step, unsigned
// operands only; the caller handles signs.
module div_iter
  import hilo_pkg::*;
#(
  parameter int unsigned STEPS = DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int unsigned CntW = $clog2(STEPS + 1);

  logic [DATA_W-1:0] quo_q, rem_q, dvs_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W:0]   rem_shift, diff;

  // The dividend shifts out of quo_q as quotient bits shift in.
  assign rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};

  // High during the step that produces the last quotient bit.
  assign done      = step && (cnt_q == CntW'(STEPS - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + 1'b1;
      if (!diff[DATA_W]) begin
        rem_q <= diff[DATA_W-1:0];
        quo_q <= {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_q <= rem_shift[DATA_W-1:0];
        quo_q <= {quo_q[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage HI/LO sequencer: runs MULT/MULTU/DIV/DIVU as multi-cycle jobs with a
// pipeline stall, and writes MTHI/MTLO straight through, one write per instruction.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_STEPS  = DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ready,
  input  logic              flush,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              stall,
  output logic              hi_we,
  output logic              lo_we,
  output logic [DATA_W-1:0] hi_wdata,
  output logic [DATA_W-1:0] lo_wdata
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [2:0]          op_q;
  logic                sa_q, sb_q, dz_q;
  logic [2*DATA_W-1:0] prod_q;

  logic                is_job, is_div, op_signed, sa, sb, b_zero, accept;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] mul_a, mul_b, mul_res;
  logic                div_start, div_step, div_done;
  logic [DATA_W-1:0]   quotient, remainder;
  logic [DATA_W-1:0]   hi_res, lo_res;

  assign is_job    = op_valid && !op[2];
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sa        = op_signed && src_a[DATA_W-1];
  assign sb        = op_signed && src_b[DATA_W-1];
  assign b_zero    = (src_b == '0);
  assign abs_a     = sa ? -src_a : src_a;
  assign abs_b     = sb ? -src_b : src_b;
  assign accept    = (state_q == StIdle) && is_job && !flush && ready;

  // Both operands extended to 64 bits; the low 64 product bits are exact for
  // signed and unsigned alike.
  assign mul_a   = {{DATA_W{(op_q == OP_MULT) && a_q[DATA_W-1]}}, a_q};
  assign mul_b   = {{DATA_W{(op_q == OP_MULT) && b_q[DATA_W-1]}}, b_q};
  assign mul_res = mul_a * mul_b;

  assign div_start = accept && is_div && !b_zero;
  assign div_step  = (state_q == StDiv) && ready && !flush;

  div_iter #(
    .STEPS (DIV_STEPS)
  ) u_div_iter (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_MULT;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      prod_q  <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else if (ready) begin
      unique case (state_q)
        StIdle: begin
          if (is_job) begin
            a_q  <= src_a;
            b_q  <= src_b;
            op_q <= op;
            sa_q <= sa;
            sb_q <= sb;
            dz_q <= is_div && b_zero;
            if (!is_div) begin
              state_q <= StMul;
              cnt_q   <= CntW'(MUL_CYCLES);
            end else if (b_zero) begin
              state_q <= StDone;
            end else begin
              state_q <= StDiv;
            end
          end
        end
        StMul: begin
          prod_q <= mul_res;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_q <= StDone;
        end
        StDiv: begin
          if (div_done) state_q <= StDone;
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    hi_res = prod_q[2*DATA_W-1:DATA_W];
    lo_res = prod_q[DATA_W-1:0];
    if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
      if (dz_q) begin
        hi_res = a_q;
        lo_res = '1;
      end else begin
        hi_res = sa_q ? -remainder : remainder;
        lo_res = (sa_q ^ sb_q) ? -quotient : quotient;
      end
    end
  end

  always_comb begin
    stall    = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_wdata = '0;
    lo_wdata = '0;
    if (reset && !flush) begin
      unique case (state_q)
        StIdle: begin
          if (is_job) begin
            stall = 1'b1;
          end else if (op_valid && (op == OP_MTHI)) begin
            hi_we    = 1'b1;
            hi_wdata = src_a;
          end else if (op_valid && (op == OP_MTLO)) begin
            lo_we    = 1'b1;
            lo_wdata = src_a;
          end
        end
        StMul, StDiv: stall = 1'b1;
        StDone: begin
          hi_we    = 1'b1;
          lo_we    = 1'b1;
          hi_wdata = hi_res;
          lo_wdata = lo_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: expected HI/LO pairs are queued at issue
// and compared when the write pulse appears.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  localparam int unsigned MulCycles = 4;
  localparam int unsigned DivSteps  = 32;

  logic        clock = 1'b0;
  logic        reset, ready, flush, op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  bit          wrote;

  hilo_muldiv_ctrl #(
    .MUL_CYCLES (MulCycles),
    .DIV_STEPS  (DivSteps)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ready    (ready),
    .flush    (flush),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .stall    (stall),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference results as {HI, LO}, from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      la, lb, q, r;
    logic [63:0] ua, ub, uq, ur;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      OP_MULT:  return 64'(la * lb);
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Entered and left just after a rising edge.
  task automatic run_job(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int freeze_at);
    int          stalls;
    int          exp_stall;
    bit          done;
    logic [63:0] e;
    exp_q.push_back(model(o, a, b));
    exp_stall = (o == OP_DIV || o == OP_DIVU) ? ((b == 0) ? 1 : 1 + DivSteps) : 1 + MulCycles;
    if (freeze_at >= 0) exp_stall += 4;
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    stalls   = 0;
    done     = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      ready = !(freeze_at >= 0 && cyc >= freeze_at && cyc < freeze_at + 4);
      @(negedge clock);
      if (stall) stalls++;
      if (hi_we || lo_we) begin
        done = 1'b1;
        check("job_we", {hi_we, lo_we}, 2'b11);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check("job_hi", hi_wdata, e[63:32]);
        check("job_lo", lo_wdata, e[31:0]);
        check("job_stall_cycles", stalls, exp_stall);
      end
      @(posedge clock);
      #1;
    end
    ready    = 1'b1;
    op_valid = 1'b0;
    if (!done) check("job_timeout", 0, 1);
    @(negedge clock);
    check("job_idle_after", {stall, hi_we, lo_we}, 3'b000);
    @(posedge clock);
    #1;
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int we_seen = 0;
    int st_seen = 0;
    repeat (n) begin
      @(negedge clock);
      if (hi_we || lo_we) we_seen++;
      if (stall) st_seen++;
      @(posedge clock);
      #1;
    end
    check({tag, "_we_pulses"}, we_seen, 0);
    check({tag, "_stall_cycles"}, st_seen, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    ready    = 1'b1;
    flush    = 1'b0;
    op_valid = 1'b1;
    op       = OP_MTHI;
    src_a    = 32'hDEAD_BEEF;
    src_b    = '0;
    @(negedge clock);
    check("reset_outputs", {stall, hi_we, lo_we, hi_wdata, lo_wdata}, '0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset    = 1'b1;
    op_valid = 1'b0;
    @(negedge clock);
    check("idle_outputs", {stall, hi_we, lo_we}, 3'b000);
    @(posedge clock);
    #1;

    // Single-cycle moves.
    op_valid = 1'b1;
    op       = OP_MTHI;
    src_a    = 32'hDEAD_BEEF;
    @(negedge clock);
    check("mthi_we", {stall, hi_we, lo_we}, 3'b010);
    check("mthi_data", hi_wdata, 32'hDEAD_BEEF);
    @(posedge clock);
    #1;
    op    = OP_MTLO;
    src_a = 32'h0BAD_F00D;
    @(negedge clock);
    check("mtlo_we", {stall, hi_we, lo_we}, 3'b001);
    check("mtlo_data", lo_wdata, 32'h0BAD_F00D);
    @(posedge clock);
    #1;
    op_valid = 1'b0;

    // Directed jobs, including the boundary cases.
    run_job(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_job(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_job(OP_DIV,   -32'sd7,       32'd2,         -1);
    run_job(OP_DIVU,  32'd100,       32'd7,         -1);
    run_job(OP_DIVU,  32'h1234,      32'd0,         -1);
    run_job(OP_DIV,   32'hFFFF_FFF0, 32'd0,         -1);
    run_job(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_job(OP_MULT,  32'h8000_0000, 32'd3,          2);
    run_job(OP_DIV,   32'd12345,     -32'sd77,       5);

    // Flush mid-divide: no write, then a clean multiply.
    op_valid = 1'b1;
    op       = OP_DIV;
    src_a    = 32'd1000;
    src_b    = 32'd3;
    repeat (11) @(posedge clock);
    #1;
    flush    = 1'b1;
    op_valid = 1'b0;
    @(negedge clock);
    check("flush_cycle", {stall, hi_we, lo_we}, 3'b000);
    @(posedge clock);
    #1;
    flush = 1'b0;
    expect_quiet("flush_after", 40);
    run_job(OP_MULT, 32'd3, 32'd5, -1);

    // Reset mid-multiply discards the job.
    op_valid = 1'b1;
    op       = OP_MULT;
    src_a    = 32'd9;
    src_b    = 32'd9;
    repeat (2) @(posedge clock);
    #1;
    reset    = 1'b0;
    op_valid = 1'b0;
    @(negedge clock);
    check("reset_mid_outputs", {stall, hi_we, lo_we}, 3'b000);
    @(posedge clock);
    #1;
    reset = 1'b1;
    expect_quiet("reset_after", 10);

    // Freeze while in DONE: write held, single job, no re-accept on exit.
    exp_q.push_back(model(OP_MULTU, 32'd7, 32'd9));
    op_valid = 1'b1;
    op       = OP_MULTU;
    src_a    = 32'd7;
    src_b    = 32'd9;
    wrote    = 1'b0;
    for (int c = 0; c < 50 && !wrote; c++) begin
      @(negedge clock);
      if (hi_we && lo_we) wrote = 1'b1;
      else begin
        @(posedge clock);
        #1;
      end
    end
    check("hold_reached", wrote, 1'b1);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    ready = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      @(negedge clock);
      check("hold_we", {stall, hi_we, lo_we}, 3'b011);
      check("hold_data", {hi_wdata, lo_wdata}, exp_v);
    end
    ready = 1'b1;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    expect_quiet("hold_after", 10);

    // Random mix through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 2 == 1) b = b >> 20;
      if (i % 4 == 2) b = '0;
      run_job(o, a, b, -1);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
